// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_stage_reg family of stage-boundary registers.
// Purely declarative: no logic, no latency, no backpressure of its own.
package pipe_pkg;

  localparam int PIPE_DATA_W     = 32;
  localparam int PIPE_CTRL_W     = 8;
  localparam int PIPE_CTRL_MAX_W = 64;

  // Bubble control word; sliced down to the instance's CTRL_W.
  localparam logic [PIPE_CTRL_MAX_W-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage entry (valid, data, ctrl): load captures data_i/ctrl_i, clear drops the entry.
// Updates on the next clock edge. No backpressure: the owner decides when to load or clear.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d,  data_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;

  // Clear wins over load and leaves the payload in place.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP[CTRL_W-1:0];
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush; PIPE_STAGE_SKID_EN adds a skid slot and flopped in_ready.
// Latency 1 cycle, one entry per cycle; stall holds the head entry, in_ready drops when storage is full.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  ps_state_t         state_d, state_q;
  logic              in_fire, out_fire;
  logic              main_load, main_clr;
  logic [DATA_W-1:0] main_data_in;
  logic [CTRL_W-1:0] main_ctrl_in;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_load, skid_clr, main_from_skid;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // The skid valid flop is high exactly in PS_TWO, so in_ready is flop-driven.
  assign in_ready     = !skid_valid;
  assign main_data_in = main_from_skid ? skid_data : in_data;
  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl)
  );
`else
  assign in_ready     = !out_valid | out_ready;
  assign main_data_in = in_data;
  assign main_ctrl_in = in_ctrl;
`endif

  pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .data_i  (main_data_in),
    .ctrl_i  (main_ctrl_in),
    .valid_o (out_valid),
    .data_o  (out_data),
    .ctrl_o  (out_ctrl)
  );

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
`endif
    // Flush discards whatever handshakes happen in the same cycle.
    if (flush) begin
      state_d  = PS_EMPTY;
      main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = PS_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = PS_TWO;
`endif
          end
        end
        PS_TWO: begin
`ifdef PIPE_STAGE_SKID_EN
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = PS_ONE;
          end
`else
          state_d = PS_EMPTY;
`endif
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; honours PIPE_STAGE_SKID_EN for in_ready expectations.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;

  int   vectors    = 0;
  int   miscompares = 0;
  ent_t sb[$];
  logic [31:0] items [3];

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
  );

  always #5 clk = ~clk;

  // Monitor: compare against the model, then advance it by what the coming edge will do.
  always @(negedge clk) begin
    bit exp_rdy;
    if (!rst) begin
      sb.delete();
    end else begin
      exp_rdy = SKID ? (sb.size() < 2) : ((sb.size() == 0) || (out_ready === 1'b1));
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL mon_in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
      end
      vectors++;
      if (out_valid !== (sb.size() != 0)) begin
        miscompares++;
        $display("FAIL mon_out_valid t=%0t got %b want %b", $time, out_valid, sb.size() != 0);
      end
      if (sb.size() != 0) begin
        vectors++;
        if ({out_data, out_ctrl} !== sb[0]) begin
          miscompares++;
          $display("FAIL mon_head t=%0t got %h/%h want %h/%h", $time, out_data, out_ctrl, sb[0].d, sb[0].c);
        end
      end else begin
        vectors++;
        if (out_ctrl !== 8'h00) begin
          miscompares++;
          $display("FAIL mon_idle_ctrl t=%0t got %h want 00", $time, out_ctrl);
        end
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
        if (in_valid && in_ready) sb.push_back('{d: in_data, c: in_ctrl});
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_init got v=%b d=%h c=%h want 0/0/0", out_valid, out_data, out_ctrl);
    end
    next();
    rst = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h3C;
    next();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h77) begin
      miscompares++;
      $display("FAIL reset_pre_load got v=%b d=%h want 1/00000077", out_valid, out_data);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async got v=%b d=%h c=%h want 0/0/0", out_valid, out_data, out_ctrl);
    end
    next();
    rst = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = i; in_ctrl = i[7:0];
      next();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== i || out_ctrl !== i[7:0]) begin
        miscompares++;
        $display("FAIL stream_%0d got v=%b d=%h c=%h want 1/%h/%h", i, out_valid, out_data, out_ctrl, i, i[7:0]);
      end
    end
    in_valid = 1'b0;
    next();
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
      miscompares++;
      $display("FAIL stream_drain got v=%b c=%h want 0/00", out_valid, out_ctrl);
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    logic [31:0] got[$];
    items[0] = 32'hA; items[1] = 32'hB; items[2] = 32'hC;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = (idx < 3);
      in_data  = items[idx < 3 ? idx : 2];
      in_ctrl  = 8'hA0 + 8'(idx);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      next();
    end
    vectors++;
    if (idx != (SKID ? 2 : 1)) begin
      miscompares++;
      $display("FAIL stall_accepted got %0d want %0d", idx, SKID ? 2 : 1);
    end
    vectors++;
    if (in_ready !== 1'b0 || out_data !== 32'hA) begin
      miscompares++;
      $display("FAIL stall_hold got rdy=%b d=%h want 0/0000000a", in_ready, out_data);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && got.size() < 3; cyc++) begin
      in_valid = (idx < 3);
      in_data  = items[idx < 3 ? idx : 2];
      in_ctrl  = 8'hA0 + 8'(idx);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) got.push_back(out_data);
      next();
    end
    in_valid = 1'b0;
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL stall_release_count got %0d want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got[k] !== items[k]) begin
          miscompares++;
          $display("FAIL stall_order_%0d got %h want %h", k, got[k], items[k]);
        end
      end
    end
    next();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1; in_ctrl = 8'h11;
    next();
    in_data = 32'hA2; in_ctrl = 8'h22;
    next();
    in_data = 32'hF0; in_ctrl = 8'hFF; flush = 1'b1;
    next();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_state got v=%b c=%h rdy=%b want 0/00/1", out_valid, out_ctrl, in_ready);
    end
    vectors++;
    if (out_data !== 32'hA1) begin
      miscompares++;
      $display("FAIL flush_data_kept got %h want 000000a1", out_data);
    end
    next();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_discard got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_simul();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5; in_ctrl = 8'h05;
    next();
    in_data = 32'h6; in_ctrl = 8'h06; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_data !== 32'h5) begin
      miscompares++;
      $display("FAIL simul_pre got rdy=%b d=%h want 1/00000005", in_ready, out_data);
    end
    next();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h6 || out_ctrl !== 8'h06 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_swap got v=%b d=%h c=%h rdy=%b want 1/00000006/06/1", out_valid, out_data, out_ctrl, in_ready);
    end
    next();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_single got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = $urandom;
      in_ctrl   = 8'($urandom_range(1, 255));
      next();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) next();
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL random_drain got left=%0d v=%b want 0/0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_simul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register, the next-generation replacement for the fixed-field ID/EX register. It carries a generic payload plus a control field between two pipeline stages using a valid/ready handshake, supports back-pressure (stall) and synchronous flush (bubble insertion), and optionally adds a 2-entry skid buffer so `in_ready` is registered and full throughput survives stalls. It is instantiated at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `DATA_W`, 32: payload width (operands, PC, dest, etc.). Retained on flush.
- `CTRL_W`, 8: control-field width (EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, Br_type). Zeroed on flush/bubble.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous flush, active-high.
- `in_valid` input 1: upstream entry valid.
- `in_ready` output 1: register can accept this cycle.
- `in_data` input DATA_W: upstream payload.
- `in_ctrl` input CTRL_W: upstream control.
- `out_valid` output 1: entry presented downstream.
- `out_ready` input 1: downstream accepts; low = stall.
- `out_data` output DATA_W: payload of head entry.
- `out_ctrl` output CTRL_W: control of head entry; 0 whenever `out_valid`=0.

## Operation
- Transfer in: `in_fire` = `in_valid & in_ready`. Transfer out: `out_fire` = `out_valid & out_ready`.
- Storage: main slot (drives outputs) and, with skid enabled, one skid slot.
- States: EMPTY (no entries), ONE (main valid), TWO (main + skid valid; skid mode only).
- EMPTY: `in_fire` -> ONE, main <= in.
- ONE: `in_fire & out_fire` -> ONE, main <= in; `in_fire & !out_fire` -> TWO, skid <= in; `!in_fire & out_fire` -> EMPTY; else hold.
- TWO: `in_ready`=0; `out_fire` -> ONE, main <= skid; else hold.
- Draining to EMPTY clears main ctrl to 0; main data holds last value.
- `flush`: any state -> EMPTY next edge; all ctrl registers 0, valid bits 0, data untouched. Flush overrides `in_fire`/`out_fire` in the same cycle; an entry handshaked during a flush cycle is discarded on the input side and counts as consumed on the output side.
- Entries leave in arrival order; no entry duplicated or dropped except by flush.
- Reset (`rst`=0, any time, including mid-transfer): state EMPTY, `out_valid`=0, `out_data`=0, `out_ctrl`=0, skid cleared; `in_ready`=1 in skid mode, 1 (combinational) otherwise.

## Timing
- Latency: entry accepted at edge N appears on `out_*` after edge N (visible in cycle N+1).
- Throughput: one entry per cycle when `out_ready` stays high.
- Skid mode: `in_ready` is a flop output (= state != TWO); no combinational path `out_ready` -> `in_ready`.
- Non-skid mode: `in_ready` = `!out_valid | out_ready` (combinational); max one stored entry.
- `out_valid`, `out_data`, `out_ctrl` are always flop-driven.
- `in_valid` may deassert without handshake; the block imposes no protocol on upstream.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-slot skid buffer, states EMPTY/ONE/TWO, registered `in_ready`.
- Undefined: single slot, states EMPTY/ONE only, combinational `in_ready`; TWO unreachable and skid storage absent. Handshake semantics, latency, flush and reset behaviour identical.

## Structure
- Shared package `pipe_pkg`: state enum (`PS_EMPTY`, `PS_ONE`, `PS_TWO`), `CTRL_NOP` constant (all zeros), default widths.
- Sub-module `pipe_stage_slot`: one storage entry (valid, data, ctrl) with load, clear-ctrl and async active-low reset; instantiated once (main) or twice (main + skid).

## Test plan
- Reset: drive traffic, assert `rst`=0 mid-stream -> `out_valid`=0, `out_ctrl`=0, `out_data`=0 immediately; after release, `in_ready`=1.
- Streaming: `out_ready`=1, send data 1..16, ctrl 0x01..0x10 on consecutive cycles -> same sequence out, 1-cycle latency, no gaps.
- Stall: send 0xA, 0xB, 0xC with `out_ready`=0 -> skid mode: `in_ready` drops after 2 accepted, 0xC held upstream; release -> 0xA, 0xB, 0xC in order. Non-skid: `in_ready` drops after 1.
- Flush in TWO with `in_valid`=1 -> next cycle `out_valid`=0, `out_ctrl`=0, incoming entry discarded, `in_ready`=1.
- Simultaneous in/out in ONE: main 0x5, push 0x6 with `out_ready`=1 -> 0x5 consumed, 0x6 presented next cycle, state stays ONE.
- Random valid/ready toggling, 10k cycles, both macro settings -> scoreboard order/content match, ctrl 0 whenever `out_valid`=0.
